// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: issues single-cycle ALU ops and runs a radix-2 restoring divider.
// Latency: ALU ops 1+ALU_LAT cycles; divide specials 1 cycle; normal divide W+2 cycles.
// Backpressure: one op in flight; req_ready only in IDLE; result held in DONE until resp_ready.
//
// Ports:
//   clk, rstn (sync, active-low), flush (sync abort of any in-flight op)
//   req_*   : issue handshake plus op kind and divide operands
//   alu_*   : one-cycle enable pulse out, registered ALU result in
//   resp_*  : result handshake; resp_result is stable while resp_valid is high
//   busy    : controller is not idle
module alu_exec_ctrl #(
    parameter int W       = 32,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_is_div,
    input  logic         req_signed,
    input  logic         req_rem,
    input  logic [W-1:0] req_rs1,
    input  logic [W-1:0] req_rs2,
    output logic         alu_enabled,
    input  logic [W-1:0] alu_result,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_result,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        ALU_ISSUE,
        ALU_WAIT,
        DIV_RUN,
        DIV_FIX,
        DONE
    } state_t;

    localparam int CW = $clog2(W + ALU_LAT) + 1;
    localparam logic [CW-1:0] STEP_LAST = CW'(W - 1);
    localparam logic [CW-1:0] ALU_LAST  = CW'(ALU_LAT - 1);
    localparam logic [W-1:0]  MIN_NEG   = {1'b1, {(W-1){1'b0}}};

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    // Divider working registers. quo starts as |dividend| and fills with quotient bits
    // as the dividend shifts out; for special cases it carries the final answer instead.
    logic [W-1:0]  quo;
    logic [W-1:0]  rem;
    logic [W-1:0]  dvs;
    logic          neg_q;
    logic          neg_r;
    logic          sel_rem;
    logic          spec;
    logic          div_start;
    logic [W-1:0]  resp_q;

    logic          accept;
    logic          spec_in;
    logic [W-1:0]  spec_res;
    logic [W-1:0]  abs1;
    logic [W-1:0]  abs2;
    logic [W:0]    rem_sh;
    logic [W:0]    diff;
    logic [W-1:0]  q_fix;
    logic [W-1:0]  r_fix;

    assign accept = req_valid && (state == IDLE);

    // Operand conditioning and special-case detection at accept time.
    always_comb begin
        abs1     = (req_signed && req_rs1[W-1]) ? -req_rs1 : req_rs1;
        abs2     = (req_signed && req_rs2[W-1]) ? -req_rs2 : req_rs2;
        spec_in  = 1'b0;
        spec_res = '0;
        if (req_rs2 == '0) begin
            spec_in  = 1'b1;
            spec_res = req_rem ? req_rs1 : '1;
        end else if (req_signed && (req_rs1 == MIN_NEG) && (req_rs2 == '1)) begin
            spec_in  = 1'b1;
            spec_res = req_rem ? '0 : MIN_NEG;
        end
    end

    // One restoring step: the W+1 bit difference's MSB is the borrow.
    always_comb begin
        rem_sh = {rem, quo[W-1]};
        diff   = rem_sh - {1'b0, dvs};
        q_fix  = neg_q ? -quo : quo;
        r_fix  = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        req_ready   = (state == IDLE);
        alu_enabled = (state == ALU_ISSUE);
        resp_valid  = (state == DONE);
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = req_is_div ? DIV_RUN : ALU_ISSUE;
                    cnt_nxt   = '0;
                end
            end
            ALU_ISSUE: begin
                state_nxt = ALU_WAIT;
                cnt_nxt   = '0;
            end
            ALU_WAIT: begin
                if (cnt == ALU_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DIV_RUN: begin
                // The first cycle only resolves special cases; steps follow.
                if (div_start) begin
                    if (spec) state_nxt = DONE;
                end else if (cnt == STEP_LAST) begin
                    state_nxt = DIV_FIX;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DIV_FIX: state_nxt = DONE;
            DONE: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort wins over any handshake in the same cycle.
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            sel_rem   <= 1'b0;
            spec      <= 1'b0;
            div_start <= 1'b0;
            resp_q    <= '0;
        end else if (flush) begin
            div_start <= 1'b0;
        end else begin
            if (accept && req_is_div) begin
                quo       <= spec_in ? spec_res : abs1;
                rem       <= '0;
                dvs       <= abs2;
                neg_q     <= req_signed && (req_rs1[W-1] ^ req_rs2[W-1]);
                neg_r     <= req_signed && req_rs1[W-1];
                sel_rem   <= req_rem;
                spec      <= spec_in;
                div_start <= 1'b1;
            end
            case (state)
                ALU_WAIT: begin
                    if (cnt == ALU_LAST) resp_q <= alu_result;
                end
                DIV_RUN: begin
                    if (div_start) begin
                        div_start <= 1'b0;
                        if (spec) resp_q <= quo;
                    end else if (diff[W]) begin
                        rem <= rem_sh[W-1:0];
                        quo <= {quo[W-2:0], 1'b0};
                    end else begin
                        rem <= diff[W-1:0];
                        quo <= {quo[W-2:0], 1'b1};
                    end
                end
                DIV_FIX: resp_q <= sel_rem ? r_fix : q_fix;
                default: ;
            endcase
        end
    end

    assign resp_result = resp_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_div = 1'b0;
    logic        req_signed = 1'b0;
    logic        req_rem = 1'b0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic        alu_enabled;
    logic [31:0] alu_result = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic        busy;

    logic [31:0] alu_val = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    alu_exec_ctrl dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_div(req_is_div), .req_signed(req_signed), .req_rem(req_rem),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .alu_enabled(alu_enabled), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Registered single-cycle ALU stand-in: output follows enable by one edge.
    always @(posedge clk) if (alu_enabled) alu_result <= alu_val;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input bit sgn, input bit rm,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 0) return rm ? a : 32'hFFFF_FFFF;
        if (!sgn) return rm ? a % b : a / b;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return rm ? 32'h0 : MIN_NEG;
        sa = $signed(a);
        sb = $signed(b);
        return rm ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic int ref_lat(input bit is_div, input bit sgn,
                                   input logic [31:0] a, input logic [31:0] b);
        if (!is_div) return 2;
        if (b == 0 || (sgn && a == MIN_NEG && b == 32'hFFFF_FFFF)) return 1;
        return 34;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_alu_en"}, alu_enabled, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_result"}, resp_result, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Issue one op, check latency/result/pulse count, optionally back-pressure, then handshake.
    task automatic run_op(input bit is_div, input bit sgn, input bit rm,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] aval,
                          input int hold, input bit eager, input bit spam);
        logic [31:0] exp;
        logic [31:0] held;
        int          lat;
        int          en_seen;
        int          bad;
        exp = is_div ? ref_div(sgn, rm, a, b) : aval;
        chk("issue_req_ready", req_ready, 1);
        alu_val    = aval;
        req_valid  = 1'b1;
        req_is_div = is_div;
        req_signed = sgn;
        req_rem    = rm;
        req_rs1    = a;
        req_rs2    = b;
        resp_ready = eager;
        @(posedge clk); #1;
        req_valid = spam;
        if (spam) begin
            req_is_div = $urandom_range(0, 1);
            req_rs1    = $urandom;
            req_rs2    = $urandom;
        end
        chk("alu_en_e0", alu_enabled, !is_div);
        chk("busy_e0", busy, 1);
        chk("req_ready_e0", req_ready, 0);
        en_seen = alu_enabled;
        lat = 0;
        bad = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (alu_enabled) en_seen++;
            if (resp_valid) begin
                lat = k;
                break;
            end
            if (req_ready || !busy) bad++;
        end
        req_valid = 1'b0;
        chk("latency", lat, ref_lat(is_div, sgn, a, b));
        chk("wait_ready_busy", bad, 0);
        chk("alu_en_pulses", en_seen, is_div ? 0 : 1);
        chk("result", resp_result, exp);
        if (lat == 0) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end else begin
            if (!eager) begin
                held = resp_result;
                bad = 0;
                for (int k = 0; k < hold; k++) begin
                    @(posedge clk); #1;
                    if (resp_result !== held || !resp_valid || req_ready) bad++;
                end
                chk("backpressure_stable", bad, 0);
                resp_ready = 1'b1;
            end
            @(posedge clk); #1;
            resp_ready = 1'b0;
            chk("post_hs_valid", resp_valid, 0);
            chk("post_hs_ready", req_ready, 1);
        end
    endtask

    // Start an op and abort it with flush or reset after n edges.
    task automatic abort_op(input bit is_div, input int n, input bit use_rst, input int watch);
        int seen;
        alu_val    = $urandom;
        req_valid  = 1'b1;
        req_is_div = is_div;
        req_signed = 1'b0;
        req_rem    = 1'b0;
        req_rs1    = $urandom;
        req_rs2    = $urandom_range(1, 1000);
        @(posedge clk); #1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        if (use_rst) rstn = 1'b0; else flush = 1'b1;
        @(posedge clk); #1;
        rstn  = 1'b1;
        flush = 1'b0;
        if (use_rst) check_reset_outputs("abort_rst");
        else begin
            chk("abort_resp_valid", resp_valid, 0);
            chk("abort_req_ready", req_ready, 1);
            chk("abort_alu_en", alu_enabled, 0);
            chk("abort_busy", busy, 0);
        end
        seen = 0;
        for (int k = 0; k < watch; k++) begin
            @(posedge clk); #1;
            if (resp_valid || busy) seen++;
        end
        chk("abort_quiet", seen, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(0, 0, 0, 0, 0, 32'd12, 0, 0, 0);
        run_op(1, 0, 0, 32'd100, 32'd7, 0, 0, 0, 0);
        run_op(1, 0, 1, 32'd100, 32'd7, 0, 0, 0, 0);
        run_op(1, 1, 0, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
        run_op(1, 1, 1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
        run_op(1, 1, 0, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, 0);
        run_op(1, 1, 0, 32'd5, 32'd0, 0, 0, 0, 0);
        run_op(1, 1, 1, 32'd5, 32'd0, 0, 0, 0, 0);
        run_op(1, 1, 0, MIN_NEG, 32'hFFFF_FFFF, 0, 0, 0, 0);
        run_op(1, 1, 1, MIN_NEG, 32'hFFFF_FFFF, 0, 0, 0, 0);
        run_op(1, 0, 0, 32'd1000, 32'd10, 0, 5, 0, 0);
        run_op(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 1, 1);
        run_op(1, 1, 1, 32'd5, 32'd0, 0, 0, 1, 0);

        // Abort during DIV_RUN step 10, then recover
        abort_op(1, 11, 0, 40);
        run_op(1, 0, 0, 32'd9, 32'd3, 0, 0, 0, 0);
        abort_op(1, 11, 1, 40);
        run_op(1, 0, 0, 32'd9, 32'd3, 0, 0, 0, 0);

        // Flush beats an accept in the same cycle
        req_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("flush_vs_accept_busy", busy, 0);

        // Flush while holding a result in DONE
        abort_op(0, 3, 0, 3);

        // Randomized ops
        for (int i = 0; i < 120; i++) begin
            logic [31:0] a, b;
            bit          d, s, r;
            d = ($urandom_range(0, 3) != 0);
            s = $urandom_range(0, 1);
            r = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0: a = MIN_NEG;
                1: a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 20);
                3: b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_op(d, s, r, a, b, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0)
                abort_op($urandom_range(0, 1), $urandom_range(0, 36),
                         $urandom_range(0, 1), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
